fir_filter_tdm: RTL
===================

# fir_filter_tdm

Parametrised, time-multiplexed successor to the direct-form FIR filter. It computes y[n] = sum over k of h[k]·x[n−k] with a single multiply-accumulate unit that iterates over all taps. It adds a valid/ready sample handshake, runtime-loadable coefficients, parametrised widths and tap count, and round-half-up output scaling with saturation. It sits between the sample source (file reader or ADC front end) and the output sink; one sample is processed at a time.

## Interface
- DATA_W, 16: signed input sample width
- COEF_W, 16: signed coefficient width
- TAPS, 123: number of taps (≥2)
- OUT_W, 17: signed output width
- SHIFT, 15: arithmetic right shift applied to the accumulator before output (≥0)
- ACC_W, DATA_W+COEF_W+7: accumulator width; must be ≥ DATA_W+COEF_W+clog2(TAPS)
- clk  in  1  sole clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high; dominates every other input
- in_valid  in  1  input_signal is valid
- in_ready  out  1  block accepts a sample; high only in IDLE
- input_signal  in  DATA_W  signed sample
- out_valid  out  1  single-cycle pulse; output_signal and sat_flag are valid
- output_signal  out  OUT_W  signed filtered sample; held until the next out_valid
- sat_flag  out  1  the current output_signal was clamped; held with output_signal
- busy  out  1  high in MAC and DONE
- coef_we  in  1  coefficient write strobe
- coef_addr  in  clog2(TAPS)  tap index k
- coef_data  in  COEF_W  signed h[k]

## Operation
- **Storage:** TAPS-entry circular delay line with write pointer wr_ptr, plus a TAPS-entry coefficient register file. Both are cleared to 0 by rst.
- **FSM states:** IDLE → MAC → DONE → IDLE.
- **IDLE:** in_ready=1. On in_valid:
  - write the sample to buf[wr_ptr];
  - clear the accumulator and set k=0;
  - go to MAC.
- **MAC:** one cycle per tap.
  - Each cycle: acc += buf[(wr_ptr − k) mod TAPS] · h[k], using a full-precision signed product of DATA_W+COEF_W bits, sign-extended to ACC_W.
  - Go to DONE when k=TAPS−1.
- **DONE:**
  - r = (acc + 2^(SHIFT−1)) >>> SHIFT; no rounding term when SHIFT=0.
  - Clamp r to [−2^(OUT_W−1), 2^(OUT_W−1)−1]. sat_flag=1 if a clamp occurred.
  - Register output_signal and sat_flag, pulse out_valid.
  - Advance wr_ptr (TAPS−1 wraps to 0) and return to IDLE.
- **Pre-history:** samples before the first accepted sample count as 0. After TAPS further samples, an input has fully aged out of the delay line.
- **No output backpressure:** out_valid is not held for the sink.
- **Coefficient writes:**
  - Applied in IDLE only.
  - Ignored while busy=1.
  - Ignored when coef_addr ≥ TAPS.
  - A write on the same edge as a sample accept is applied, and is used for that sample.
- **in_valid while busy:** ignored; the sample is not captured.
- **Reset mid-operation:** the FSM returns to IDLE, the accumulator, delay line, coefficients and wr_ptr are cleared, and any pending result is dropped (no out_valid).

## Timing
- **Reset values (after the rst edge):** in_ready=1, busy=0, out_valid=0, output_signal=0, sat_flag=0.
- **Cycle sequence,** with the accept edge at t0:
  - MAC edges t1…tTAPS;
  - DONE edge tTAPS+1, after which out_valid=1 for exactly one cycle.
- **Latency:** TAPS+1 cycles from accept to output (124 at defaults).
- **Next accept:** at tTAPS+2 at the earliest, so one sample per TAPS+2 cycles (125 at defaults).
- **Signal timing relative to the accept edge:**
  - in_ready falls immediately after the accept edge and rises together with out_valid.
  - busy is the complement of in_ready.

## Test plan
1. **Impulse response, wrap-around:** rst, then load h[k]=100·k. Feed x=16384, then zeros, with in_valid held high. Require output n = 50·n for n=0…122, outputs 0 from n=123 on, and sat_flag=0 throughout.
2. **Handshake and latency:** hold in_valid=1 continuously. Require accepts exactly 125 cycles apart and out_valid exactly 124 cycles after each accept. Toggling input_signal while busy=1 must not change results.
3. **Saturation:** set all h[k]=32767 and feed 123 samples of 32767; the last output must be 65535 with sat_flag=1. Repeat with −32768; the last output must be −65536 with sat_flag=1.
4. **Rounding:** set h[0]=1, all others 0. Inputs 16384, 16383, −16384, −16385 must give outputs 1, 0, 0, −1 respectively.
5. **Coefficient gating:**
   - A write to h[0] while busy=1 has no effect.
   - A write to coef_addr=123 has no effect.
   - A write of h[0]=32767 on the same edge as accepting x=16384 gives output 16384 (32767·16384 = 536854528, plus 2^14, shifted right by 15).
6. **Reset mid-MAC:** assert rst for 1 cycle, 50 cycles into MAC. Require no out_valid and in_ready=1 after reset. A subsequent impulse must give 0 outputs, since coefficients are cleared.

Source files
------------

// File: rtl/fir_filter_tdm.sv
// Time-multiplexed FIR: one shared MAC walks all TAPS taps per sample, round-half-up + saturate on output.
// Latency TAPS+1 cycles accept-to-out_valid; in_ready low while computing, no output backpressure.
module fir_filter_tdm #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 123,
  parameter int OUT_W  = 17,
  parameter int SHIFT  = 15,
  parameter int ACC_W  = DATA_W + COEF_W + 7,
  localparam int AW    = $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] input_signal,
  output logic                     out_valid,
  output logic signed [OUT_W-1:0]  output_signal,
  output logic                     sat_flag,
  output logic                     busy,
  input  logic                     coef_we,
  input  logic [AW-1:0]            coef_addr,
  input  logic signed [COEF_W-1:0] coef_data
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MAC  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int RW     = ACC_W + 1;
  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic [AW:0]            TAPS_N  = (AW+1)'(TAPS);
  localparam logic [AW-1:0]          TAPS_A  = AW'(TAPS);
  localparam logic [AW-1:0]          K_LAST  = AW'(TAPS - 1);
  localparam logic [AW-1:0]          ONE_A   = AW'(1);
  localparam logic signed [RW-1:0]   RND     = (SHIFT > 0) ? (RW'(1) << RND_SH) : '0;
  localparam logic signed [RW-1:0]   OUT_MAX = {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [RW-1:0]   OUT_MIN = {{(RW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  if (TAPS < 2) begin : g_bad_taps
    $error("fir_filter_tdm: TAPS must be at least 2");
  end
  if (ACC_W < DATA_W + COEF_W + $clog2(TAPS)) begin : g_bad_acc
    $error("fir_filter_tdm: ACC_W too narrow for worst-case sum");
  end

  logic [1:0]               state;
  logic [AW-1:0]            wr_ptr;
  logic [AW-1:0]            k;
  logic signed [ACC_W-1:0]  acc;
  logic signed [DATA_W-1:0] dline [TAPS];
  logic signed [COEF_W-1:0] coef  [TAPS];

  logic [AW-1:0]            rd_idx;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [RW-1:0]     acc_rnd;
  logic signed [RW-1:0]     acc_sh;
  logic signed [OUT_W-1:0]  out_clamped;
  logic                     out_sat;
  logic                     coef_wr;

  assign in_ready = (state == ST_IDLE);
  assign busy     = ~in_ready;
  assign coef_wr  = in_ready & coef_we & ({1'b0, coef_addr} < TAPS_N);

  // (wr_ptr - k) mod TAPS; the wrapped case stays below TAPS so AW-bit modular math is exact
  always_comb begin
    if (wr_ptr >= k) begin
      rd_idx = wr_ptr - k;
    end else begin
      rd_idx = wr_ptr - k + TAPS_A;
    end
  end

  always_comb begin
    prod     = PROD_W'(dline[rd_idx]) * PROD_W'(coef[k]);
    prod_ext = ACC_W'(prod);
  end

  always_comb begin
    acc_rnd     = RW'(acc) + RND;
    acc_sh      = acc_rnd >>> SHIFT;
    out_clamped = acc_sh[OUT_W-1:0];
    out_sat     = 1'b0;
    if (acc_sh > OUT_MAX) begin
      out_clamped = OUT_MAX[OUT_W-1:0];
      out_sat     = 1'b1;
    end else if (acc_sh < OUT_MIN) begin
      out_clamped = OUT_MIN[OUT_W-1:0];
      out_sat     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      wr_ptr        <= '0;
      k             <= '0;
      acc           <= '0;
      out_valid     <= 1'b0;
      output_signal <= '0;
      sat_flag      <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        dline[i] <= '0;
        coef[i]  <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      // Coefficient update lands on the accept edge too, so the new h[k] is used by this sample
      if (coef_wr) begin
        coef[coef_addr] <= coef_data;
      end
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            dline[wr_ptr] <= input_signal;
            acc           <= '0;
            k             <= '0;
            state         <= ST_MAC;
          end
        end
        ST_MAC: begin
          acc <= acc + prod_ext;
          if (k == K_LAST) begin
            state <= ST_DONE;
          end else begin
            k <= k + ONE_A;
          end
        end
        ST_DONE: begin
          output_signal <= out_clamped;
          sat_flag      <= out_sat;
          out_valid     <= 1'b1;
          wr_ptr        <= (wr_ptr == K_LAST) ? '0 : wr_ptr + ONE_A;
          state         <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
